// File: rtl/hdma_pkg.sv
// Shared types and constants for the CGB VRAM DMA controller.
package hdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GDMA_REQ,
    ST_HDMA_WAIT,
    ST_HDMA_REQ,
    ST_RD,
    ST_WR
  } hdma_state_t;

  localparam logic [2:0] REG_SRC_HI = 3'd0;
  localparam logic [2:0] REG_SRC_LO = 3'd1;
  localparam logic [2:0] REG_DST_HI = 3'd2;
  localparam logic [2:0] REG_DST_LO = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int unsigned BLOCK_BYTES = 16;

endpackage

// File: rtl/hdma_controller_if.sv
// Register-window, CPU-bus, VRAM and PPU-status signals of the HDMA controller.
interface hdma_controller_if #(
  parameter int unsigned VRAM_AW = 13
);
  logic               reg_target;
  logic [2:0]         reg_select;
  logic               reg_write;
  logic [7:0]         reg_wdata;
  logic [7:0]         reg_rdata;
  logic               cgb_mode;
  logic               lcd_enable;
  logic               hblank_start;
  logic               cpu_halted;
  logic               cpu_stall;
  logic               bus_grant;
  logic [15:0]        src_addr;
  logic               src_rd;
  logic [7:0]         src_rdata;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_wdata;
  logic               vram_we;
  logic               active;

  // master: the DMA controller itself
  modport master (
    input  reg_target, reg_select, reg_write, reg_wdata,
    input  cgb_mode, lcd_enable, hblank_start, cpu_halted, bus_grant, src_rdata,
    output reg_rdata, cpu_stall, src_addr, src_rd, vram_addr, vram_wdata, vram_we, active
  );

  modport slave (
    output reg_target, reg_select, reg_write, reg_wdata,
    output cgb_mode, lcd_enable, hblank_start, cpu_halted, bus_grant, src_rdata,
    input  reg_rdata, cpu_stall, src_addr, src_rd, vram_addr, vram_wdata, vram_we, active
  );

endinterface

// File: rtl/hdma_xfer_engine.sv
// Byte mover for one block: alternating bus-read / VRAM-write phases with the
// source/destination pointers and byte counter.
module hdma_xfer_engine
  import hdma_pkg::*;
#(
  parameter int unsigned VRAM_AW    = 13,
  parameter int unsigned BLOCK_LOG2 = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_src_we,
  input  logic [15:0]        i_src_wdata,
  input  logic               i_dst_we,
  input  logic [VRAM_AW-1:0] i_dst_wdata,
  input  logic [7:0]         i_src_rdata,
  output logic [15:0]        o_src,
  output logic [VRAM_AW-1:0] o_dst,
  output logic               o_src_rd,
  output logic               o_vram_we,
  output logic [7:0]         o_vram_wdata,
  output logic               o_block_done
);

  hdma_state_t             r_phase;
  logic [15:0]             r_src;
  logic [VRAM_AW-1:0]      r_dst;
  logic [BLOCK_LOG2-1:0]   r_byte_cnt;
  logic                    w_last;
  logic                    w_wr;

  assign w_last = &r_byte_cnt;
  assign w_wr   = (r_phase == ST_WR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase    <= ST_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (i_src_we) r_src <= i_src_wdata;
      if (i_dst_we) r_dst <= i_dst_wdata;
      case (r_phase)
        ST_RD: r_phase <= ST_WR;
        ST_WR: begin
          r_src      <= r_src + 16'd1;
          r_dst      <= r_dst + VRAM_AW'(1);
          r_byte_cnt <= r_byte_cnt + BLOCK_LOG2'(1);
          // a start on the last write chains straight into the next block
          r_phase    <= (w_last && !i_start) ? ST_IDLE : ST_RD;
        end
        default: if (i_start) r_phase <= ST_RD;
      endcase
    end
  end

  assign o_src        = r_src;
  assign o_dst        = r_dst;
  assign o_src_rd     = (r_phase == ST_RD);
  assign o_vram_we    = w_wr;
  assign o_vram_wdata = w_wr ? i_src_rdata : '0;
  assign o_block_done = w_wr && w_last;

endmodule

// File: rtl/hdma_controller.sv
// CGB VRAM DMA controller (FF51-FF55): GDMA/HDMA sequencing and CPU stall.
// Optional macro HDMA_LCD_OFF_BLOCK_EN: HDMA start with LCD off moves one block immediately.
module hdma_controller
  import hdma_pkg::*;
#(
  parameter int unsigned VRAM_AW    = 13,
  parameter int unsigned BLOCK_LOG2 = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  hdma_controller_if.master  bus
);

  hdma_state_t        r_state;
  logic               r_hdma;
  logic               r_cpu_stall;
  logic               r_active;
  logic [7:0]         r_remaining;

  logic               w_reg_wr;
  logic               w_ctrl_wr;
  logic               w_ptr_ok;
  logic               w_grant_ok;
  logic               w_last_block;
  logic               w_start;
  logic               w_block_done;
  logic [7:0]         w_len;
  logic [6:0]         w_rem_m1;
  logic               w_src_we;
  logic               w_dst_we;
  logic [15:0]        w_src;
  logic [15:0]        w_src_wdata;
  logic [VRAM_AW-1:0] w_dst;
  logic [VRAM_AW-1:0] w_dst_wdata;

  assign w_reg_wr     = bus.reg_target && bus.reg_write && bus.cgb_mode;
  assign w_ctrl_wr    = w_reg_wr && (bus.reg_select == REG_CTRL);
  assign w_ptr_ok     = (r_state == ST_IDLE) || (r_state == ST_HDMA_WAIT);
  assign w_len        = {1'b0, bus.reg_wdata[6:0]} + 8'd1;
  assign w_rem_m1     = r_remaining[6:0] - 7'd1;
  assign w_last_block = (r_remaining == 8'd1);
  assign w_grant_ok   = ((r_state == ST_GDMA_REQ) || (r_state == ST_HDMA_REQ)) &&
                        r_cpu_stall && bus.bus_grant;
  assign w_start      = w_grant_ok ||
                        ((r_state == ST_WR) && w_block_done && !w_last_block && !r_hdma);

  always_comb begin
    w_src_we    = 1'b0;
    w_dst_we    = 1'b0;
    w_src_wdata = w_src;
    w_dst_wdata = w_dst;
    if (w_reg_wr && w_ptr_ok) begin
      case (bus.reg_select)
        REG_SRC_HI: begin
          w_src_we    = 1'b1;
          w_src_wdata = {bus.reg_wdata, w_src[7:0]};
        end
        REG_SRC_LO: begin
          w_src_we    = 1'b1;
          w_src_wdata = {w_src[15:8], bus.reg_wdata[7:4], 4'h0};
        end
        REG_DST_HI: begin
          w_dst_we    = 1'b1;
          w_dst_wdata = {bus.reg_wdata[VRAM_AW-9:0], w_dst[7:0]};
        end
        REG_DST_LO: begin
          w_dst_we    = 1'b1;
          w_dst_wdata = {w_dst[VRAM_AW-1:8], bus.reg_wdata[7:4], 4'h0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_hdma      <= 1'b0;
      r_cpu_stall <= 1'b0;
      r_active    <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ctrl_wr) begin
          r_remaining <= w_len;
          r_active    <= 1'b1;
          r_hdma      <= bus.reg_wdata[7];
          if (!bus.reg_wdata[7]) begin
            r_state <= ST_GDMA_REQ;
          end else begin
`ifdef HDMA_LCD_OFF_BLOCK_EN
            r_state <= bus.lcd_enable ? ST_HDMA_WAIT : ST_HDMA_REQ;
`else
            r_state <= ST_HDMA_WAIT;
`endif
          end
        end
        ST_HDMA_WAIT: begin
          if (w_ctrl_wr) begin
            if (bus.reg_wdata[7]) begin
              r_remaining <= w_len;
            end else begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end else if (bus.hblank_start && bus.lcd_enable && !bus.cpu_halted) begin
            r_state <= ST_HDMA_REQ;
          end
        end
        ST_GDMA_REQ, ST_HDMA_REQ: begin
          r_cpu_stall <= 1'b1;
          if (w_grant_ok) r_state <= ST_RD;
        end
        ST_RD: r_state <= ST_WR;
        ST_WR: begin
          if (w_block_done) begin
            r_remaining <= r_remaining - 8'd1;
            if (w_last_block) begin
              r_state     <= ST_IDLE;
              r_cpu_stall <= 1'b0;
              r_active    <= 1'b0;
            end else if (r_hdma) begin
              r_state     <= ST_HDMA_WAIT;
              r_cpu_stall <= 1'b0;
            end else begin
              r_state <= ST_RD;
            end
          end else begin
            r_state <= ST_RD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  hdma_xfer_engine #(
    .VRAM_AW   (VRAM_AW),
    .BLOCK_LOG2(BLOCK_LOG2)
  ) u_engine (
    .i_clk       (clk),
    .i_rst_n     (n_rst),
    .i_start     (w_start),
    .i_src_we    (w_src_we),
    .i_src_wdata (w_src_wdata),
    .i_dst_we    (w_dst_we),
    .i_dst_wdata (w_dst_wdata),
    .i_src_rdata (bus.src_rdata),
    .o_src       (w_src),
    .o_dst       (w_dst),
    .o_src_rd    (bus.src_rd),
    .o_vram_we   (bus.vram_we),
    .o_vram_wdata(bus.vram_wdata),
    .o_block_done(w_block_done)
  );

  assign bus.src_addr  = w_src;
  assign bus.vram_addr = w_dst;
  assign bus.cpu_stall = r_cpu_stall;
  assign bus.active    = r_active;
  assign bus.reg_rdata = (bus.cgb_mode && bus.reg_target && (bus.reg_select == REG_CTRL)) ?
                         {~r_active, w_rem_m1} : 8'hFF;

endmodule

// File: tb/tb_hdma_controller.sv
// Randomized bench for hdma_controller against a block-level transfer model.
module tb_hdma_controller;
  import hdma_pkg::*;

  localparam int unsigned AW = 13;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  hdma_controller_if #(.VRAM_AW(AW)) bus_if ();

  hdma_controller #(.VRAM_AW(AW), .BLOCK_LOG2(4)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]    mem [65536];
  wr_t           obs_q[$];
  wr_t           exp_q[$];
  logic [15:0]   rd_q[$];
  int unsigned   xfer_cycles = 0;

  logic [15:0]   m_src = '0;
  logic [AW-1:0] m_dst = '0;
  int            m_rem = 0;
  logic          m_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus responder and VRAM write monitor
  always @(negedge clk) begin
    if (bus_if.src_rd) begin
      bus_if.src_rdata = mem[bus_if.src_addr];
      rd_q.push_back(bus_if.src_addr);
    end
    if (bus_if.vram_we) obs_q.push_back({bus_if.vram_addr, bus_if.vram_wdata});
    if (bus_if.src_rd || bus_if.vram_we) xfer_cycles++;
  end

  task automatic model_block();
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      exp_q.push_back({m_dst, mem[m_src]});
      m_src++;
      m_dst++;
    end
    m_rem--;
  endtask

  function automatic logic [7:0] exp_ctrl();
    logic [6:0] r;
    r = 7'(m_rem - 1);
    return {~m_active, r};
  endfunction

  task automatic reg_wr(input logic [2:0] sel, input logic [7:0] d);
    bus_if.reg_target = 1'b1;
    bus_if.reg_write  = 1'b1;
    bus_if.reg_select = sel;
    bus_if.reg_wdata  = d;
    @(negedge clk);
    bus_if.reg_write  = 1'b0;
    bus_if.reg_target = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] sel, output logic [7:0] d);
    bus_if.reg_target = 1'b1;
    bus_if.reg_select = sel;
    #1;
    d = bus_if.reg_rdata;
    bus_if.reg_target = 1'b0;
  endtask

  task automatic check_ctrl(input string tag);
    logic [7:0] v;
    reg_rd(REG_CTRL, v);
    check(tag, v, exp_ctrl());
  endtask

  task automatic set_ptrs(input logic [7:0] sh, input logic [7:0] sl,
                          input logic [7:0] dh, input logic [7:0] dl);
    reg_wr(REG_SRC_HI, sh);
    reg_wr(REG_SRC_LO, sl);
    reg_wr(REG_DST_HI, dh);
    reg_wr(REG_DST_LO, dl);
    m_src = {sh, sl[7:4], 4'h0};
    m_dst = {dh[4:0], dl[7:4], 4'h0};
  endtask

  task automatic rand_ptrs();
    set_ptrs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget; i++) begin
      if (!bus_if.active) break;
      @(negedge clk);
    end
    if (bus_if.active) check({tag, " timeout"}, 32'd1, 32'd0);
  endtask

  task automatic hblank();
    bus_if.hblank_start = 1'b1;
    @(negedge clk);
    bus_if.hblank_start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    wr_t o, e;
    check({tag, " count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " addr"}, 32'(o.a), 32'(e.a));
      check({tag, " data"}, 32'(o.d), 32'(e.d));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // GDMA of len blocks; bus grant withheld for grant_delay cycles first
  task automatic gdma(input int len, input int unsigned grant_delay, input string tag);
    xfer_cycles = 0;
    rd_q.delete();
    if (grant_delay > 0) bus_if.bus_grant = 1'b0;
    reg_wr(REG_CTRL, 8'(len - 1));
    m_rem    = len;
    m_active = 1'b1;
    for (int b = 0; b < len; b++) model_block();
    if (grant_delay > 0) begin
      repeat (grant_delay) @(negedge clk);
      check({tag, " stall w/o grant"}, 32'(bus_if.cpu_stall), 32'd1);
      check({tag, " no rd w/o grant"}, obs_q.size() + rd_q.size(), 32'd0);
      bus_if.bus_grant = 1'b1;
    end
    wait_idle(len * 40 + 20, tag);
    m_active = 1'b0;
    check({tag, " cycles"}, xfer_cycles, 32'(32 * len));
    check({tag, " stall low"}, 32'(bus_if.cpu_stall), 32'd0);
    check_ctrl({tag, " ff55"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int found;

    bus_if.reg_target   = 1'b0;
    bus_if.reg_select   = '0;
    bus_if.reg_write    = 1'b0;
    bus_if.reg_wdata    = '0;
    bus_if.cgb_mode     = 1'b1;
    bus_if.lcd_enable   = 1'b1;
    bus_if.hblank_start = 1'b0;
    bus_if.cpu_halted   = 1'b0;
    bus_if.bus_grant    = 1'b1;
    bus_if.src_rdata    = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check("rst stall", 32'(bus_if.cpu_stall), 0);
    check("rst active", 32'(bus_if.active), 0);
    check("rst src_rd", 32'(bus_if.src_rd), 0);
    check("rst vram_we", 32'(bus_if.vram_we), 0);
    check("rst src_addr", 32'(bus_if.src_addr), 0);
    check("rst vram_addr", 32'(bus_if.vram_addr), 0);
    check("rst vram_wdata", 32'(bus_if.vram_wdata), 0);
    check_ctrl("rst ff55");
    reg_rd(REG_SRC_HI, v);
    check("ff51 read", v, 8'hFF);
    n_rst = 1'b1;
    @(negedge clk);

    // Basic GDMA: C000 -> VRAM offset 0000
    set_ptrs(8'hC0, 8'h00, 8'h80, 8'h00);
    gdma(1, 0, "gdma c000");
    compare_writes("gdma c000");

    for (int it = 0; it < 3; it++) begin
      rand_ptrs();
      gdma(int'($urandom_range(1, 4)), (it == 1) ? 8 : 0, "gdma rand");
      compare_writes("gdma rand");
    end

    // Address wrap on both pointers
    set_ptrs(8'hFF, 8'hF0, 8'h1F, 8'hF0);
    gdma(2, 0, "wrap");
    check("wrap dst", (obs_q.size() > 16) ? 32'(obs_q[16].a) : 32'hDEAD, 0);
    check("wrap src", (rd_q.size() > 16) ? 32'(rd_q[16]) : 32'hDEAD, 0);
    compare_writes("wrap");

    // HDMA, 2 blocks, with HBlank gating
    rand_ptrs();
    reg_wr(REG_CTRL, 8'h81);
    m_rem = 2;
    m_active = 1'b1;
    repeat (40) @(negedge clk);
    check("hdma idle traffic", obs_q.size(), 0);
    check("hdma active", 32'(bus_if.active), 1);
    check_ctrl("hdma ff55 start");
    bus_if.cpu_halted = 1'b1;
    hblank();
    bus_if.cpu_halted = 1'b0;
    bus_if.lcd_enable = 1'b0;
    hblank();
    bus_if.lcd_enable = 1'b1;
    repeat (40) @(negedge clk);
    check("hdma gated traffic", obs_q.size(), 0);
    hblank();
    model_block();
    repeat (10) @(negedge clk);
    hblank();
    repeat (40) @(negedge clk);
    compare_writes("hdma b1");
    check("hdma b1 stall", 32'(bus_if.cpu_stall), 0);
    check_ctrl("hdma ff55 b1");
    hblank();
    model_block();
    wait_idle(60, "hdma b2");
    m_active = 1'b0;
    compare_writes("hdma b2");
    check_ctrl("hdma ff55 b2");

    // HDMA cancel after one block
    rand_ptrs();
    reg_wr(REG_CTRL, 8'h83);
    m_rem = 4;
    m_active = 1'b1;
    hblank();
    model_block();
    repeat (45) @(negedge clk);
    reg_wr(REG_CTRL, 8'h00);
    m_active = 1'b0;
    check("cancel active", 32'(bus_if.active), 0);
    check_ctrl("cancel ff55");
    hblank();
    repeat (5) @(negedge clk);
    hblank();
    repeat (40) @(negedge clk);
    compare_writes("cancel");

    // HDMA started with LCD off
    rand_ptrs();
    bus_if.lcd_enable = 1'b0;
    reg_wr(REG_CTRL, 8'h81);
    m_rem = 2;
    m_active = 1'b1;
`ifdef HDMA_LCD_OFF_BLOCK_EN
    model_block();
`endif
    repeat (45) @(negedge clk);
    compare_writes("lcd off start");
    check_ctrl("lcd off ff55");
    bus_if.lcd_enable = 1'b1;
    while (m_rem > 0) begin
      hblank();
      model_block();
      repeat (45) @(negedge clk);
    end
    m_active = 1'b0;
    compare_writes("lcd on resume");
    check_ctrl("lcd on ff55");

    // Non-CGB mode ignores the window
    bus_if.cgb_mode = 1'b0;
    reg_rd(REG_CTRL, v);
    check("dmg ff55 read", v, 8'hFF);
    reg_wr(REG_CTRL, 8'h00);
    repeat (5) @(negedge clk);
    check("dmg no start", 32'(bus_if.active), 0);
    bus_if.cgb_mode = 1'b1;

    // Asynchronous reset in the middle of a write
    rand_ptrs();
    reg_wr(REG_CTRL, 8'h03);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.vram_we && obs_q.size() >= 5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid-wr reached", found, 1);
    #2 n_rst = 1'b0;
    #1;
    check("arst stall", 32'(bus_if.cpu_stall), 0);
    check("arst active", 32'(bus_if.active), 0);
    check("arst src_rd", 32'(bus_if.src_rd), 0);
    check("arst vram_we", 32'(bus_if.vram_we), 0);
    check("arst src_addr", 32'(bus_if.src_addr), 0);
    check("arst vram_addr", 32'(bus_if.vram_addr), 0);
    check("arst vram_wdata", 32'(bus_if.vram_wdata), 0);
    m_src = '0;
    m_dst = '0;
    m_rem = 0;
    m_active = 1'b0;
    check_ctrl("arst ff55");
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (40) @(negedge clk);
    check("arst no writes", obs_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
